// File: rtl/sd_frame_loader.sv
// Command sequencer in front of the SD interface: runs card init once after reset,
// then issues read / stream / CRC-strip actions for every block of a frame.
module sd_frame_loader #(
  parameter int unsigned BLOCKS_PER_FRAME = 510
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] frame_base,
  output logic        busy,
  output logic        done,
  output logic        initialized,
  output logic [15:0] blk_idx,
  output logic        sd_init,
  output logic        sd_read_cmd,
  output logic        sd_stream_512B,
  output logic        sd_rm_crc,
  output logic [31:0] sd_blk_addr,
  output logic        sd_trigger,
  input  logic        sd_busy
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INIT_REQ  = 4'd1,
    ST_INIT_WAIT = 4'd2,
    ST_CMD_REQ   = 4'd3,
    ST_CMD_WAIT  = 4'd4,
    ST_DATA_REQ  = 4'd5,
    ST_DATA_WAIT = 4'd6,
    ST_CRC_REQ   = 4'd7,
    ST_CRC_WAIT  = 4'd8,
    ST_NEXT      = 4'd9,
    ST_DONE      = 4'd10
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(BLOCKS_PER_FRAME - 32'd1);

  state_t      state_r;
  state_t      state_s;
  logic        trigger_s;
  logic        guard_r;
  logic        initialized_r;
  logic [15:0] blk_idx_r;
  logic [31:0] addr_r;

  // Next-state logic; guard_r masks sd_busy on the first WAIT cycle after a trigger.
  always_comb begin
    state_s   = state_r;
    trigger_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = initialized_r ? ST_CMD_REQ : ST_INIT_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INIT_REQ: begin
        if (!sd_busy) begin
          trigger_s = 1'b1;
          state_s   = ST_INIT_WAIT;
        end else begin
          state_s   = ST_INIT_REQ;
        end
      end
      ST_INIT_WAIT: begin
        if (!guard_r && !sd_busy) begin
          state_s = ST_CMD_REQ;
        end else begin
          state_s = ST_INIT_WAIT;
        end
      end
      ST_CMD_REQ: begin
        if (!sd_busy) begin
          trigger_s = 1'b1;
          state_s   = ST_CMD_WAIT;
        end else begin
          state_s   = ST_CMD_REQ;
        end
      end
      ST_CMD_WAIT: begin
        if (!guard_r && !sd_busy) begin
          state_s = ST_DATA_REQ;
        end else begin
          state_s = ST_CMD_WAIT;
        end
      end
      ST_DATA_REQ: begin
        if (!sd_busy) begin
          trigger_s = 1'b1;
          state_s   = ST_DATA_WAIT;
        end else begin
          state_s   = ST_DATA_REQ;
        end
      end
      ST_DATA_WAIT: begin
        if (!guard_r && !sd_busy) begin
          state_s = ST_CRC_REQ;
        end else begin
          state_s = ST_DATA_WAIT;
        end
      end
      ST_CRC_REQ: begin
        if (!sd_busy) begin
          trigger_s = 1'b1;
          state_s   = ST_CRC_WAIT;
        end else begin
          state_s   = ST_CRC_REQ;
        end
      end
      ST_CRC_WAIT: begin
        if (!guard_r && !sd_busy) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_CRC_WAIT;
        end
      end
      ST_NEXT: begin
        if (blk_idx_r == LAST_IDX) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CMD_REQ;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and WAIT guard flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      guard_r <= 1'b0;
    end else begin
      state_r <= state_s;
      guard_r <= trigger_s;
    end
  end

  // Block index and running address; the address increments with the index so it wraps mod 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_idx_r <= 16'd0;
      addr_r    <= 32'd0;
    end else if (state_r == ST_IDLE && start) begin
      blk_idx_r <= 16'd0;
      addr_r    <= frame_base;
    end else if (state_r == ST_NEXT && blk_idx_r != LAST_IDX) begin
      blk_idx_r <= blk_idx_r + 16'd1;
      addr_r    <= addr_r + 32'd1;
    end else begin
      blk_idx_r <= blk_idx_r;
      addr_r    <= addr_r;
    end
  end

  // Card-initialised flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      initialized_r <= 1'b0;
    end else if (state_r == ST_INIT_WAIT && state_s == ST_CMD_REQ) begin
      initialized_r <= 1'b1;
    end else begin
      initialized_r <= initialized_r;
    end
  end

  // Moore decode of action lines and status from the registered state.
  always_comb begin
    sd_init        = 1'b0;
    sd_read_cmd    = 1'b0;
    sd_stream_512B = 1'b0;
    sd_rm_crc      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state_r)
      ST_IDLE:                    busy           = 1'b0;
      ST_INIT_REQ, ST_INIT_WAIT:  sd_init        = 1'b1;
      ST_CMD_REQ, ST_CMD_WAIT:    sd_read_cmd    = 1'b1;
      ST_DATA_REQ, ST_DATA_WAIT:  sd_stream_512B = 1'b1;
      ST_CRC_REQ, ST_CRC_WAIT:    sd_rm_crc      = 1'b1;
      ST_NEXT:                    busy           = 1'b1;
      ST_DONE:                    done           = 1'b1;
      default:                    busy           = 1'b0;
    endcase
  end

  assign sd_trigger  = trigger_s;
  assign initialized = initialized_r;
  assign blk_idx     = blk_idx_r;
  assign sd_blk_addr = addr_r;

endmodule

// File: tb/tb_sd_frame_loader.sv
// Randomised bench for sd_frame_loader: an SD-interface busy model drives the DUT and a
// frame-level reference (trigger list, addresses, latency) checks every load.
module tb_sd_frame_loader;

  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] frame_base;
  logic        busy, done, initialized;
  logic [15:0] blk_idx;
  logic        sd_init, sd_read_cmd, sd_stream_512B, sd_rm_crc;
  logic [31:0] sd_blk_addr;
  logic        sd_trigger;
  logic        sd_busy;

  sd_frame_loader #(.BLOCKS_PER_FRAME(B)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_base(frame_base),
    .busy(busy), .done(done), .initialized(initialized), .blk_idx(blk_idx),
    .sd_init(sd_init), .sd_read_cmd(sd_read_cmd), .sd_stream_512B(sd_stream_512B),
    .sd_rm_crc(sd_rm_crc), .sd_blk_addr(sd_blk_addr), .sd_trigger(sd_trigger),
    .sd_busy(sd_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc, trig_n, done_n, done_cyc, busy_err, onehot_err, busy_cnt, stall_left, stall_req;
  bit pulse_mid, pulse_done, prev_stream;
  logic [31:0] cur_base;
  int lat_plan[$];
  logic [51:0] trig_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, initialized, blk_idx, sd_init, sd_read_cmd, sd_stream_512B,
                sd_rm_crc, sd_blk_addr, sd_trigger});
  endfunction

  // Observe one cycle at the falling edge.
  task automatic sample();
    logic [3:0] acts;
    bit exp_busy;
    @(negedge clk);
    acts = {sd_init, sd_read_cmd, sd_stream_512B, sd_rm_crc};
    exp_busy = (cyc >= 1) && (done_n == 0);
    if (busy !== exp_busy) busy_err++;
    if ($countones(acts) > 1 || (!exp_busy && acts != 4'd0)) onehot_err++;
    if (sd_trigger === 1'b1) begin
      trig_log.push_back({acts, sd_read_cmd ? blk_idx : 16'd0, sd_read_cmd ? sd_blk_addr : 32'd0});
      busy_cnt = (trig_n < lat_plan.size()) ? lat_plan[trig_n] : 0;
      trig_n++;
    end
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
  endtask

  // Drive inputs just after the rising edge: stray start pulses, injected stall, busy model.
  task automatic drive();
    start = 1'b0;
    if (pulse_mid && cyc == 8) begin
      start = 1'b1;
      frame_base = ~cur_base;
    end
    if (pulse_done && done === 1'b1) begin
      start = 1'b1;
      frame_base = cur_base + 32'h1000;
    end
    if (stall_req > 0 && sd_stream_512B && !prev_stream) begin
      stall_left = stall_req;
      stall_req = 0;
    end
    prev_stream = sd_stream_512B;
    if (stall_left > 0) begin
      sd_busy = 1'b1;
      stall_left--;
    end else if (busy_cnt > 0) begin
      sd_busy = 1'b1;
      busy_cnt--;
    end else begin
      sd_busy = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    sample();
  endtask

  task automatic begin_frame(input logic [31:0] base, input int stall, input bit pm, input bit pd);
    trig_log.delete();
    trig_n = 0; done_n = 0; done_cyc = -1; busy_err = 0; onehot_err = 0;
    busy_cnt = 0; stall_left = 0; stall_req = stall;
    pulse_mid = pm; pulse_done = pd; cur_base = base; prev_stream = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
    start = 1'b1;
    frame_base = base;
    sd_busy = 1'b0;
    sample();
  endtask

  task automatic run_frame(input string name, input logic [31:0] base, input bit cold,
                           input int lmin, input int lmax, input int stall,
                           input bit pm, input bit pd);
    logic [51:0] exp_q[$];
    int exp_done, nph, l;
    nph = 3 * B + (cold ? 1 : 0);
    lat_plan.delete();
    exp_done = 1 + B + stall;
    for (int i = 0; i < nph; i++) begin
      l = $urandom_range(lmax, lmin);
      lat_plan.push_back(l);
      exp_done += (l + 2 > 3) ? l + 2 : 3;
    end
    if (cold) exp_q.push_back({4'b1000, 16'd0, 32'd0});
    for (int k = 0; k < B; k++) begin
      exp_q.push_back({4'b0100, 16'(k), base + 32'(k)});
      exp_q.push_back({4'b0010, 16'd0, 32'd0});
      exp_q.push_back({4'b0001, 16'd0, 32'd0});
    end
    begin_frame(base, stall, pm, pd);
    while (done_n == 0 && cyc < 1000) tick();
    for (int i = 0; i < 4; i++) tick();
    start = 1'b0;
    check($sformatf("%s.ntrig", name), 64'(trig_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < trig_log.size())
        check($sformatf("%s.trig%0d", name, i), 64'(trig_log[i]), 64'(exp_q[i]));
    end
    check($sformatf("%s.ndone", name), 64'(done_n), 64'd1);
    check($sformatf("%s.done_cycle", name), 64'(done_cyc), 64'(exp_done));
    check($sformatf("%s.busy_window", name), 64'(busy_err), 64'd0);
    check($sformatf("%s.action_onehot", name), 64'(onehot_err), 64'd0);
    check($sformatf("%s.initialized", name), 64'(initialized), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    frame_base = 32'd0;
    sd_busy = 1'b0;
    #1;
    check("reset.outputs", all_outs(), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_frame("cold", 32'h0000_0100, 1'b1, 3, 3, 0, 1'b0, 1'b0);
    run_frame("warm", $urandom, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    run_frame("wrap", 32'hFFFF_FFFF, 1'b0, 0, 4, 0, 1'b0, 1'b0);
    run_frame("stall", $urandom, 1'b0, 0, 0, 5, 1'b0, 1'b0);
    run_frame("ignore_start", $urandom, 1'b0, 0, 4, 0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a DATA_WAIT phase.
    lat_plan = '{2, 2, 2, 2, 2, 2, 2};
    begin_frame(32'h0000_2000, 0, 1'b0, 1'b0);
    while (trig_n < 2 && cyc < 200) tick();
    tick();
    check("rst.in_data_wait", 64'({sd_stream_512B, sd_trigger}), 64'b10);
    #2;
    rst = 1'b1;
    #1;
    check("rst.async_outputs", all_outs(), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sd_busy = 1'b0;
    busy_cnt = 0;
    start = 1'b0;
    run_frame("post_rst", $urandom, 1'b1, 0, 4, 0, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++)
      run_frame($sformatf("rand%0d", r), $urandom, 1'b0, 0, 4, $urandom_range(3, 0), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_frame_loader.md
# sd_frame_loader

Sequencer directly upstream of the SD interface block. It drives the SD interface's action strobes, block address and trigger so that one full frame of consecutive 512-byte blocks is pulled from the card. A single `start` request covers the whole frame. The block also performs card initialisation once after reset. Pixel data never passes through this block; it only orchestrates the command and flow-control side.

## Interface
Parameters:
- `BLOCKS_PER_FRAME`, default 510: 512-byte blocks per frame (480×272 RGB565). Legal range 1..65535.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request one frame load; sampled only in IDLE.
- `frame_base` in 32: first block address; captured on the accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until IDLE is re-entered.
- `done` out 1: one-cycle pulse when the frame completes.
- `initialized` out 1: card init has completed since the last reset.
- `blk_idx` out 16: index of the block currently being fetched (0-based).
- `sd_init`, `sd_read_cmd`, `sd_stream_512B`, `sd_rm_crc` out 1 each: one-hot action select to the SD interface.
- `sd_blk_addr` out 32: block address to the SD interface.
- `sd_trigger` out 1: one-cycle action start pulse.
- `sd_busy` in 1: SD interface busy.

## Operation
- FSM states: IDLE, INIT_REQ, INIT_WAIT, CMD_REQ, CMD_WAIT, DATA_REQ, DATA_WAIT, CRC_REQ, CRC_WAIT, NEXT, DONE.
- IDLE transitions on `start`=1:
  - INIT_REQ if `initialized`=0, else CMD_REQ.
  - Either way, `frame_base` is latched and `blk_idx` is cleared.
- Any `*_REQ` state:
  - If `sd_busy`=0: assert `sd_trigger` for exactly this cycle and go to the matching `*_WAIT`.
  - If `sd_busy`=1: stay in the state with no trigger (stall).
- Any `*_WAIT` state:
  - The first cycle is a guard cycle; `sd_busy` is ignored.
  - On any later cycle with `sd_busy`=0, advance.
  - Contract with the SD interface: `sd_busy` rises no later than the cycle after `sd_trigger`.
- Advance order:
  - INIT_WAIT → CMD_REQ, and sets `initialized`.
  - CMD_WAIT → DATA_REQ.
  - DATA_WAIT → CRC_REQ.
  - CRC_WAIT → NEXT.
- NEXT:
  - If `blk_idx` = BLOCKS_PER_FRAME−1 → DONE.
  - Else increment `blk_idx` and go to CMD_REQ.
- DONE: `done`=1 for this single cycle, then IDLE.
- Action lines:
  - Exactly one is high through each REQ and its WAIT: init for INIT_*, read_cmd for CMD_*, stream_512B for DATA_*, rm_crc for CRC_*.
  - All are low in IDLE, NEXT and DONE.
- `sd_blk_addr` = latched base + `blk_idx`, 32-bit unsigned, modulo 2^32 (wraps through 0xFFFFFFFF → 0). It is valid and stable throughout CMD_* and constant across a trigger.
- `start` while not IDLE: ignored and not queued; `frame_base` changes are ignored.
- `start` in the DONE cycle: ignored. The earliest accepted `start` is in the first IDLE cycle after DONE.

## Timing
- Reset value of every output is 0: `busy`, `done`, `initialized`, `blk_idx`, all action lines, `sd_blk_addr`, `sd_trigger`.
- Reset is asynchronous and may occur mid-frame. The FSM returns to IDLE immediately and `initialized` clears, so the next frame re-runs init.
- All outputs are registered or decoded from the registered state (Moore); there is no combinational path from `sd_busy` or `start` to any output except `sd_trigger`. `sd_trigger` = REQ state ∧ ¬`sd_busy`.
- Per phase with `sd_busy` low when sampled: REQ 1 cycle + WAIT 2 cycles = 3 cycles.
- Per block: 3 phases + NEXT = 10 cycles.
- Latency with `start` sampled in cycle 0 and `sd_busy` low whenever sampled:
  - Warm (already initialized): `done` high in cycle 10·B+1.
  - Cold: `done` high in cycle 10·B+4.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- Each stall cycle in REQ or extra `sd_busy` cycle in WAIT adds exactly one cycle.

## Test plan
- Cold load, B=2, `frame_base`=0x100, `sd_busy` model high for 3 cycles after each trigger → trigger sequence init, rd, str, crc, rd, str, crc (7 triggers); `sd_blk_addr` 0x100 then 0x101; one `done`; `initialized`=1.
- Warm load, B=2, `sd_busy` held 0 → no `sd_init`; `done` exactly in cycle 21 after `start`; `busy` high cycles 1..21.
- Wrap: `frame_base`=0xFFFFFFFF, B=2 → addresses 0xFFFFFFFF then 0x00000000.
- Stall: `sd_busy`=1 on entry to DATA_REQ for 5 cycles → no trigger during the stall; trigger on the first cycle `sd_busy`=0; total latency +5.
- `start` pulsed mid-frame and again in the DONE cycle with different `frame_base` → both ignored, exactly one `done`, addresses unchanged.
- `rst` asserted during DATA_WAIT → all outputs 0 asynchronously; the next `start` re-issues `sd_init` first.
